// File: rtl/prbs_checker.sv
// PRBS-8 (x^8 + x^6 + 1) stream checker: fill/verify acquisition, free-running lock and
// windowed loss-of-lock detection. Optional macro PRBS_CHK_INVERT_EN inverts bit_in on entry.
module prbs_checker #(
    parameter int unsigned LOCK_CNT    = 16,
    parameter int unsigned WINDOW      = 64,
    parameter int unsigned LOSS_THRESH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        bit_in,
    input  logic        bit_valid,
    input  logic        clear_cnt,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_count
);

    typedef enum logic [1:0] {StFill, StVerify, StLock} state_e;

    state_e     state;
    logic [7:0] hist;
    logic [2:0] fill_cnt;
    logic [7:0] good_cnt;
    logic [7:0] win_cnt;
    logic [7:0] win_err;

    logic       rx_bit;
    logic       pred_bit;
    logic       mismatch;
    logic       count_err;
    logic [7:0] hist_rx;
    logic [7:0] win_err_inc;

`ifdef PRBS_CHK_INVERT_EN
    assign rx_bit = ~bit_in;
`else
    assign rx_bit = bit_in;
`endif

    assign pred_bit    = hist[7] ^ hist[5];
    assign mismatch    = rx_bit ^ pred_bit;
    assign hist_rx     = {hist[6:0], rx_bit};
    assign count_err   = bit_valid && (state == StLock) && mismatch;
    assign win_err_inc = win_err + {7'd0, count_err};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= StFill;
            hist      <= 8'd0;
            fill_cnt  <= 3'd0;
            good_cnt  <= 8'd0;
            win_cnt   <= 8'd0;
            win_err   <= 8'd0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= 16'd0;
        end else begin
            err_pulse <= count_err;
            // A clear that coincides with a counted error leaves that error counted.
            if (clear_cnt) begin
                err_count <= {15'd0, count_err};
            end else if (count_err && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end

            if (bit_valid) begin
                unique case (state)
                    StFill: begin
                        hist <= hist_rx;
                        if (fill_cnt == 3'd7) begin
                            fill_cnt <= 3'd0;
                            good_cnt <= 8'd0;
                            // An all-zero history is the LFSR lock-up state; refill instead.
                            if (hist_rx != 8'd0) begin
                                state <= StVerify;
                            end
                        end else begin
                            fill_cnt <= fill_cnt + 3'd1;
                        end
                    end
                    StVerify: begin
                        hist <= hist_rx;
                        if (mismatch) begin
                            state    <= StFill;
                            fill_cnt <= 3'd0;
                            good_cnt <= 8'd0;
                        end else if (good_cnt == 8'(LOCK_CNT - 1)) begin
                            state    <= StLock;
                            locked   <= 1'b1;
                            good_cnt <= 8'd0;
                            win_cnt  <= 8'd0;
                            win_err  <= 8'd0;
                        end else begin
                            good_cnt <= good_cnt + 8'd1;
                        end
                    end
                    StLock: begin
                        // Free-run on the prediction so one channel error costs one mismatch.
                        hist <= {hist[6:0], pred_bit};
                        if (win_err_inc >= 8'(LOSS_THRESH)) begin
                            state    <= StFill;
                            locked   <= 1'b0;
                            fill_cnt <= 3'd0;
                            good_cnt <= 8'd0;
                            win_cnt  <= 8'd0;
                            win_err  <= 8'd0;
                        end else if (win_cnt == 8'(WINDOW - 1)) begin
                            win_cnt <= 8'd0;
                            win_err <= 8'd0;
                        end else begin
                            win_cnt <= win_cnt + 8'd1;
                            win_err <= win_err_inc;
                        end
                    end
                    default: begin
                        state <= StFill;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prbs_checker.sv
// Randomized self-checking bench for prbs_checker against a bit-queue reference model.
module tb_prbs_checker;

    localparam int unsigned LockCnt    = 16;
    localparam int unsigned Window     = 64;
    localparam int unsigned LossThresh = 4;
`ifdef PRBS_CHK_INVERT_EN
    localparam bit Inv = 1'b1;
`else
    localparam bit Inv = 1'b0;
`endif

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b1;
    logic        bit_in    = 1'b0;
    logic        bit_valid = 1'b0;
    logic        clear_cnt = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;

    prbs_checker #(
        .LOCK_CNT   (LockCnt),
        .WINDOW     (Window),
        .LOSS_THRESH(LossThresh)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bit_in   (bit_in),
        .bit_valid(bit_valid),
        .clear_cnt(clear_cnt),
        .locked   (locked),
        .err_pulse(err_pulse),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Generator: shift-left, taps 7 and 5, output is the LSB.
    logic [7:0] gen;
    task automatic gen_bit(output bit b);
        b   = gen[0];
        gen = {gen[6:0], gen[7] ^ gen[5]};
    endtask

    // Reference model: phase 0 = fill, 1 = verify, 2 = lock; last 8 bits, oldest at front.
    int m_phase, m_fill, m_good, m_wcnt, m_werr, m_err;
    bit m_pulse;
    bit m_hist[$];

    task automatic model_reset();
        m_phase = 0; m_fill = 0; m_good = 0; m_wcnt = 0; m_werr = 0; m_err = 0;
        m_pulse = 0;
        m_hist.delete();
        for (int i = 0; i < 8; i++) m_hist.push_back(1'b0);
    endtask

    task automatic model_step(input bit v, input bit b, input bit clr);
        bit pred;
        bit counted;
        bit all_zero;
        counted = 0;
        if (v) begin
            pred = m_hist[0] ^ m_hist[2];
            if (m_phase == 0) begin
                m_hist.push_back(b); void'(m_hist.pop_front());
                m_fill++;
                if (m_fill == 8) begin
                    m_fill = 0;
                    all_zero = 1;
                    foreach (m_hist[i]) if (m_hist[i]) all_zero = 0;
                    if (!all_zero) begin m_phase = 1; m_good = 0; end
                end
            end else if (m_phase == 1) begin
                m_hist.push_back(b); void'(m_hist.pop_front());
                if (b != pred) begin
                    m_phase = 0; m_fill = 0; m_good = 0;
                end else begin
                    m_good++;
                    if (m_good == LockCnt) begin m_phase = 2; m_wcnt = 0; m_werr = 0; end
                end
            end else begin
                m_hist.push_back(pred); void'(m_hist.pop_front());
                if (b != pred) begin counted = 1; m_werr++; end
                if (m_werr >= LossThresh) begin
                    m_phase = 0; m_fill = 0; m_good = 0; m_wcnt = 0; m_werr = 0;
                end else begin
                    m_wcnt++;
                    if (m_wcnt == Window) begin m_wcnt = 0; m_werr = 0; end
                end
            end
        end
        if (clr) m_err = counted ? 1 : 0;
        else if (counted && m_err < 65535) m_err++;
        m_pulse = counted;
    endtask

    task automatic cycle(input bit v, input bit b, input bit clr);
        bit_valid = v;
        bit_in    = b ^ Inv;
        clear_cnt = clr;
        @(posedge clk);
        if (!reset_n) model_reset();
        else model_step(v, b, clr);
        #1;
        check_eq("locked", int'(locked), int'(m_phase == 2));
        check_eq("err_pulse", int'(err_pulse), int'(m_pulse));
        check_eq("err_count", int'(err_count), m_err);
    endtask

    task automatic send(input bit v, input bit flip, input bit clr);
        bit b;
        if (v) begin gen_bit(b); b = b ^ flip; end
        else b = 1'($urandom);
        cycle(v, b, clr);
    endtask

    // Counts valid bits until locked rises; returns -1 if it never does within the budget.
    task automatic measure_lock(input bit toggle, output int lock_at);
        int nvalid;
        bit v;
        nvalid  = 0;
        lock_at = -1;
        for (int i = 0; i < 120 && lock_at < 0; i++) begin
            v = toggle ? bit'(i % 2) : 1'b1;
            send(v, 1'b0, 1'b0);
            if (v) nvalid++;
            if (locked) lock_at = nvalid;
        end
    endtask

    initial begin
        int lock_at;
        bit ever_locked;
        gen = 8'hA5;
        model_reset();

        #1 reset_n = 1'b0;
        #1;
        check_eq("rst_locked", int'(locked), 0);
        check_eq("rst_err_pulse", int'(err_pulse), 0);
        check_eq("rst_err_count", int'(err_count), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;

        // Continuous clean stream from seed 0xA5.
        measure_lock(1'b0, lock_at);
        check_eq("lock_latency", lock_at, 24);
        check_eq("lock_err_count", int'(err_count), 0);
        repeat (10) send(1'b1, 1'b0, 1'b0);

        // Single flipped bit while locked.
        send(1'b1, 1'b1, 1'b0);
        check_eq("single_pulse", int'(err_pulse), 1);
        check_eq("single_count", int'(err_count), 1);
        check_eq("single_locked", int'(locked), 1);
        send(1'b1, 1'b0, 1'b0);
        check_eq("pulse_width", int'(err_pulse), 0);
        repeat (80) send(1'b1, 1'b0, 1'b0);

        // Clear alone, then four errors inside one window.
        send(1'b0, 1'b0, 1'b1);
        check_eq("clear_alone", int'(err_count), 0);
        for (int i = 0; i < int'(Window) && m_wcnt > int'(Window) - 8; i++)
            send(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) send(1'b1, 1'b1, 1'b0);
        check_eq("hold_after_3", int'(locked), 1);
        send(1'b1, 1'b1, 1'b0);
        check_eq("loss_of_lock", int'(locked), 0);
        check_eq("loss_err_count", int'(err_count), 4);
        measure_lock(1'b0, lock_at);
        check_eq("relock_latency", lock_at, 24);
        check_eq("err_retained", int'(err_count), 4);

        // Spread three more errors over separate windows to reach 7, then clear with an error.
        for (int k = 0; k < 3; k++) begin
            send(1'b1, 1'b1, 1'b0);
            repeat (70) send(1'b1, 1'b0, 1'b0);
        end
        check_eq("count_seven", int'(err_count), 7);
        send(1'b1, 1'b1, 1'b1);
        check_eq("clear_with_err", int'(err_count), 1);
        check_eq("clear_locked", int'(locked), 1);

        // Random valid gaps, flips and clears.
        for (int i = 0; i < 3000; i++)
            send(($urandom_range(3) != 0), ($urandom_range(49) == 0), ($urandom_range(199) == 0));

        // Reach lock, then assert reset asynchronously with bit_valid toggling.
        for (int i = 0; i < 200 && m_phase != 2; i++) send(($urandom_range(3) != 0), 1'b0, 1'b0);
        check_eq("pre_reset_locked", int'(locked), 1);
        for (int i = 0; i < 5; i++) send(bit'(i % 2), 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check_eq("async_locked", int'(locked), 0);
        check_eq("async_err_pulse", int'(err_pulse), 0);
        check_eq("async_err_count", int'(err_count), 0);
        for (int i = 0; i < 3; i++) send(bit'(i % 2), 1'b0, 1'b0);
        @(negedge clk) reset_n = 1'b1;
        measure_lock(1'b1, lock_at);
        check_eq("reset_relock", lock_at, 24);

        // All-zero stream never locks.
        @(negedge clk) reset_n = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        model_reset();
        ever_locked = 0;
        for (int i = 0; i < 1000; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            if (locked) ever_locked = 1;
        end
        check_eq("zero_never_lock", int'(ever_locked), 0);
        check_eq("zero_err_count", int'(err_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 Parameter LOCK_CNT, default 16: consecutive correct predicted bits required to declare lock (range 1..255).
REQ-002 Parameter WINDOW, default 64: valid-bit length of the loss-of-lock observation window (range 8..255).
REQ-003 Parameter LOSS_THRESH, default 4: mismatches within one window that force loss of lock (range 1..WINDOW).
REQ-004 The interface SHALL have one clock, and reset SHALL be asynchronous and active-low.
REQ-005 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-006 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port bit_in, input, 1 bit: received serial bit from the lfsr generator stream (generator output is the register LSB).
REQ-008 Port bit_valid, input, 1 bit: qualifies bit_in; the block SHALL ignore cycles with bit_valid=0 (no state change).
REQ-009 Port clear_cnt, input, 1 bit: synchronous clear of err_count.
REQ-010 Port locked, output, 1 bit: registered lock status.
REQ-011 Port err_pulse, output, 1 bit: one-cycle pulse per mismatch while locked.
REQ-012 Port err_count, output, 16 bits: saturating count of mismatches while locked.

Function
REQ-013 The sequence checked SHALL be s[n] = s[n-8] XOR s[n-6] (generator taps 7 and 5, shift-left, output bit 0).
REQ-014 The block SHALL hold an 8-bit history register h, where h[k] is the bit received k+1 valid bits earlier; the predicted bit SHALL be h[7] XOR h[5].
REQ-015 The FSM SHALL have states FILL, VERIFY and LOCK; after reset the state SHALL be FILL with fill count 0.
REQ-016 In FILL, each valid bit SHALL shift into h; after the 8th bit the FSM SHALL go to VERIFY, unless h is all zeros, in which case it SHALL restart FILL.
REQ-017 In VERIFY, each valid bit SHALL shift into h; a match SHALL increment the good count, and a mismatch SHALL return the FSM to FILL with counts cleared.
REQ-018 When the good count reaches LOCK_CNT, the FSM SHALL enter LOCK; locked SHALL be high from the next cycle.
REQ-019 In LOCK, h SHALL free-run on the predicted bit rather than the received bit, so that one channel error yields exactly one mismatch.
REQ-020 In LOCK, a valid mismatch SHALL assert err_pulse for exactly one cycle, in the cycle after the bit, and SHALL increment err_count, saturating at 0xFFFF.
REQ-021 In LOCK, a window counter SHALL count valid bits modulo WINDOW alongside a window error counter; both SHALL reset when a window completes.
REQ-022 When the window error count reaches LOSS_THRESH, the FSM SHALL enter FILL, and locked SHALL go low on the next cycle; err_count SHALL be retained.
REQ-023 If clear_cnt coincides with a counted mismatch, err_count SHALL become 1; clear_cnt alone SHALL make it 0.
REQ-024 The block SHALL count no errors and pulse no err_pulse outside LOCK.

Reset
REQ-025 When reset_n=0, locked, err_pulse and err_count SHALL all be 0 immediately, and h, the counters and the FSM (FILL) SHALL also clear.
REQ-026 Reset asserted mid-lock SHALL force a full FILL/VERIFY reacquisition after release.

Configuration
REQ-027 With macro PRBS_CHK_INVERT_EN defined, bit_in SHALL be inverted before all processing, to support inverting channels.
REQ-028 Without PRBS_CHK_INVERT_EN, bit_in SHALL be used as received, and no inversion logic SHALL exist.

Verification
REQ-029 Generator seeded 0xA5 feeding bit_in continuously -> locked rises the cycle after the 24th valid bit (8 fill + 16 verify); err_count=0.
REQ-030 Locked, one flipped bit injected -> a single err_pulse, err_count=1, and locked stays 1.
REQ-031 Locked, 4 flips within one 64-bit window -> locked falls after the 4th; relock after 24 clean bits; err_count=4 retained.
REQ-032 All-zero stream for 1000 bits -> locked never asserts; err_count=0.
REQ-033 clear_cnt asserted in the same cycle as a locked mismatch with err_count=7 -> err_count=1.
REQ-034 reset_n pulsed low while locked with bit_valid toggling -> all outputs 0 asynchronously; relock after 24 valid bits.
